// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file with one synchronous write port,
// two combinational read ports, an optional hardwired-zero entry 0, optional
// write-to-read bypass and a per-entry busy scoreboard for decode stalls.
module register_file #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              mark_busy,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_busy_b
);

    // DEPTH widened by one bit so range checks work for non-power-of-two depths
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             mark_ok;

    // An address holds real state only if in range and not the hardwired zero
    function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, addr} < DEPTH_W);
        is_zero  = (ZERO_REG != 0) && (addr == '0);
        return in_range && !is_zero;
    endfunction

    // Qualify write and mark requests; dropped ones never touch state
    always_comb begin
        wr_ok   = reg_write && addr_live(wr_addr);
        mark_ok = mark_busy && addr_live(mark_addr);
    end

    // Next-state for storage and scoreboard; a mark overrides a write's clear
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
                busy_d[i] = 1'b0;
            end
            if (mark_ok && (mark_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read port A: zero while in reset or for dead addresses, bypass if enabled
    always_comb begin
        rd_data_a = '0;
        rd_busy_a = 1'b0;
        if (!reset && addr_live(rd_addr_a)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr_a == ADDR_W'(i)) begin
                        rd_data_a = regs_q[i];
                        rd_busy_a = busy_q[i];
                    end
                end
            end
        end
    end

    // Read port B: identical behaviour to port A, fully independent
    always_comb begin
        rd_data_b = '0;
        rd_busy_b = 1'b0;
        if (!reset && addr_live(rd_addr_b)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr_b == ADDR_W'(i)) begin
                        rd_data_b = regs_q[i];
                        rd_busy_b = busy_q[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed tests for register_file, DEPTH=12 with zero entry.
// Two instances share all inputs: dut (BYPASS=1) and dut_nb (BYPASS=0).
module tb_register_file;

    localparam int WIDTH = 16;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic             reg_write;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             mark_busy;
    logic [AW-1:0]    mark_addr;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;
    logic             rd_busy_a, rd_busy_b, nb_busy_a, nb_busy_b;

    int checks = 0;
    int fails  = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .reset(reset), .reg_write(reg_write), .wr_addr(wr_addr),
        .wr_data(wr_data), .mark_busy(mark_busy), .mark_addr(mark_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b)
    );

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(CLK), .reset(reset), .reg_write(reg_write), .wr_addr(wr_addr),
        .wr_data(wr_data), .mark_busy(mark_busy), .mark_addr(mark_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(nb_data_a), .rd_busy_a(nb_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(nb_data_b), .rd_busy_b(nb_busy_b)
    );

    // Advance past the next rising edge, leaving time to drive and sample
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reset state, clearing of written data and busy bits, async reset pulse
    task automatic test_reset();
        reset = 1'b1; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
        mark_busy = 1'b0; mark_addr = '0; rd_addr_a = 4'd3; rd_addr_b = 4'd7;
        #2;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_busy_a !== 1'b0 || rd_data_b !== 16'h0000 || rd_busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_initial: got a=%h/%b b=%h/%b expected 0000/0 0000/0", rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
        end
        @(negedge CLK);
        reset = 1'b0;
        reg_write = 1'b1; wr_addr = 4'd3; wr_data = 16'h8888; mark_busy = 1'b1; mark_addr = 4'd7;
        tick();
        wr_addr = 4'd7; mark_addr = 4'd3;
        tick();
        reg_write = 1'b0; mark_busy = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h8888 || rd_busy_a !== 1'b1 || rd_data_b !== 16'h8888 || rd_busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_prefill: got a=%h/%b b=%h/%b expected 8888/1 8888/0", rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_busy_a !== 1'b0 || rd_data_b !== 16'h0000 || rd_busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_async: got a=%h/%b b=%h/%b expected 0000/0 0000/0", rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_busy_a !== 1'b0 || rd_data_b !== 16'h0000 || rd_busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_cleared: got a=%h/%b b=%h/%b expected 0000/0 0000/0", rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
        end
    endtask

    // Basic write, then storage holds with the enable low
    task automatic test_basic_write();
        reg_write = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; rd_addr_a = 4'd5;
        tick();
        reg_write = 1'b0; wr_data = 16'hFFFF;
        #1;
        checks++;
        if (rd_data_a !== 16'h1234) begin
            fails++;
            $display("[TB] FAIL basic_write: got %h expected 1234", rd_data_a);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rd_data_a !== 16'h1234 || nb_data_a !== 16'h1234) begin
                fails++;
                $display("[TB] FAIL basic_hold cycle %0d: got %h/%h expected 1234", c, rd_data_a, nb_data_a);
            end
        end
    endtask

    // Hardwired zero entry and out-of-range addresses
    task automatic test_zero_and_range();
        reg_write = 1'b1; wr_addr = 4'd0; wr_data = 16'hABCD; rd_addr_a = 4'd0;
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL zero_write: got %h expected 0000", rd_data_a);
        end
        mark_busy = 1'b1; mark_addr = 4'd0;
        tick();
        mark_busy = 1'b0;
        #1;
        checks++;
        if (rd_busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_mark: got busy %b expected 0", rd_busy_a);
        end
        reg_write = 1'b1; wr_addr = 4'd13; wr_data = 16'h5A5A; rd_addr_a = 4'd13;
        mark_busy = 1'b1; mark_addr = 4'd14;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL range_bypass: got %h expected 0000", rd_data_a);
        end
        tick();
        reg_write = 1'b0; mark_busy = 1'b0; rd_addr_b = 4'd14;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_busy_a !== 1'b0 || rd_busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL range_read: got %h/%b busy14 %b expected 0000/0 0", rd_data_a, rd_busy_a, rd_busy_b);
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] exp_v;
            exp_v = (i == 5) ? 16'h1234 : 16'h0000;
            rd_addr_b = AW'(i);
            #1;
            checks++;
            if (rd_data_b !== exp_v || rd_busy_b !== 1'b0) begin
                fails++;
                $display("[TB] FAIL range_entry %0d: got %h/%b expected %h/0", i, rd_data_b, rd_busy_b, exp_v);
            end
        end
    endtask

    // Same-cycle bypass on the BYPASS=1 instance versus stored value on BYPASS=0
    task automatic test_bypass();
        mark_busy = 1'b1; mark_addr = 4'd4; rd_addr_a = 4'd4;
        tick();
        mark_busy = 1'b0;
        reg_write = 1'b1; wr_addr = 4'd4; wr_data = 16'h00FF;
        #2;
        checks++;
        if (rd_data_a !== 16'h00FF || rd_busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bypass_on: got %h/%b expected 00ff/0", rd_data_a, rd_busy_a);
        end
        checks++;
        if (nb_data_a !== 16'h0000 || nb_busy_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bypass_off: got %h/%b expected 0000/1", nb_data_a, nb_busy_a);
        end
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h00FF || nb_data_a !== 16'h00FF || rd_busy_a !== 1'b0 || nb_busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bypass_after: got %h/%b %h/%b expected 00ff/0 both", rd_data_a, rd_busy_a, nb_data_a, nb_busy_a);
        end
    endtask

    // Mark sets busy; a later write clears it and stores the data
    task automatic test_scoreboard();
        mark_busy = 1'b1; mark_addr = 4'd6; rd_addr_b = 4'd6;
        tick();
        mark_busy = 1'b0;
        #1;
        checks++;
        if (rd_busy_b !== 1'b1 || nb_busy_b !== 1'b1) begin
            fails++;
            $display("[TB] FAIL score_mark: got %b/%b expected 1", rd_busy_b, nb_busy_b);
        end
        reg_write = 1'b1; wr_addr = 4'd6; wr_data = 16'h0042;
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rd_busy_b !== 1'b0 || rd_data_b !== 16'h0042) begin
            fails++;
            $display("[TB] FAIL score_clear: got %h/%b expected 0042/0", rd_data_b, rd_busy_b);
        end
    endtask

    // Mark and write on the same edge: same address and different addresses
    task automatic test_back_to_back();
        reg_write = 1'b1; wr_addr = 4'd9; wr_data = 16'h7777;
        mark_busy = 1'b1; mark_addr = 4'd9; rd_addr_a = 4'd9;
        tick();
        reg_write = 1'b0; mark_busy = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h7777 || rd_busy_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL same_mark_write: got %h/%b expected 7777/1", rd_data_a, rd_busy_a);
        end
        reg_write = 1'b1; wr_data = 16'h1111;
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h1111 || rd_busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL write_clears: got %h/%b expected 1111/0", rd_data_a, rd_busy_a);
        end
        reg_write = 1'b1; wr_addr = 4'd11; wr_data = 16'hBEEF;
        mark_busy = 1'b1; mark_addr = 4'd10; rd_addr_a = 4'd10; rd_addr_b = 4'd11;
        tick();
        reg_write = 1'b0; mark_busy = 1'b0;
        #1;
        checks++;
        if (rd_busy_a !== 1'b1 || rd_data_a !== 16'h0000 || rd_busy_b !== 1'b0 || rd_data_b !== 16'hBEEF) begin
            fails++;
            $display("[TB] FAIL independent: got a=%h/%b b=%h/%b expected 0000/1 beef/0", rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
        end
    endtask

    // Reset held across an edge that also carries a write and a mark
    task automatic test_reset_wins();
        @(negedge CLK);
        reg_write = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
        mark_busy = 1'b1; mark_addr = 4'd3; rd_addr_a = 4'd2; rd_addr_b = 4'd3;
        reset = 1'b1;
        tick();
        reg_write = 1'b0; mark_busy = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_busy_b !== 1'b0 || nb_data_a !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_wins: got %h busy3 %b nb %h expected 0000 0 0000", rd_data_a, rd_busy_b, nb_data_a);
        end
        reg_write = 1'b1; wr_data = 16'h3333;
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h3333) begin
            fails++;
            $display("[TB] FAIL post_reset_write: got %h expected 3333", rd_data_a);
        end
    endtask

    // Run all scenarios in order, then report
    initial begin
        test_reset();
        test_basic_write();
        test_zero_and_range();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_reset_wins();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
